// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: pipelined instruction-memory port, branch redirect and the
// decode-side valid/ready handshake. The master modport is the fetch queue itself.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_inst;
    logic [XLEN-1:0] id_pc_plus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output id_valid, id_inst, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  id_valid, id_inst, id_pc_plus4,
        output id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: credit-limited sequential requests, in-order response
// buffering with PC+4, first-word fall-through to decode, single-cycle redirect flush.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  io_fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUT + 1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [OW-1:0]   r_inflight;
    logic [OW-1:0]   r_drop;
    logic [31:0]     r_inst_mem [DEPTH];
    logic [XLEN-1:0] r_pc4_mem  [DEPTH];

    logic            w_credit_ok;
    logic            w_grant;
    logic            w_resp;
    logic            w_drop_resp;
    logic            w_push;
    logic            w_pop;
    logic [OW-1:0]   w_inflight_after_flush;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_unused;

    // Credits count both buffered entries and outstanding requests, so every response
    // that comes back is guaranteed a free slot.
    assign w_credit_ok = (32'(r_inflight) < MAX_OUT) &&
                         ((32'(r_count) + 32'(r_inflight)) < DEPTH);

    assign io_fq.imem_req  = !rst && !io_fq.redirect && w_credit_ok;
    assign io_fq.imem_addr = r_pc;

    assign w_grant     = io_fq.imem_req && io_fq.imem_gnt;
    assign w_resp      = io_fq.imem_rvalid;
    assign w_drop_resp = w_resp && (r_drop != '0);
    assign w_push      = w_resp && (r_drop == '0) && !io_fq.redirect;
    assign w_pop       = io_fq.id_valid && io_fq.id_ready;

    assign w_inflight_after_flush = r_inflight - OW'(w_resp);
    assign w_redirect_pc          = {io_fq.redirect_pc[XLEN-1:2], 2'b00};
    assign w_unused               = ^io_fq.redirect_pc[1:0];

    assign io_fq.id_valid    = (r_count != '0);
    assign io_fq.id_inst     = r_inst_mem[r_rd_ptr];
    assign io_fq.id_pc_plus4 = r_pc4_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (io_fq.redirect) begin
            // Everything still in flight, minus a response landing right now, is stale.
            r_pc       <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= w_inflight_after_flush;
            r_drop     <= w_inflight_after_flush;
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
                r_wr_ptr  <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_drop_resp) begin
                r_drop <= r_drop - OW'(1);
            end
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_inflight <= r_inflight + OW'(w_grant) - OW'(w_resp);
        end
    end

    // NOTE: entry storage has no reset; r_count alone decides which slots are live,
    // so resetting the array would only cost flops and reset fan-out.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= io_fq.imem_rdata;
            r_pc4_mem[r_wr_ptr]  <= r_resp_pc + XLEN'(4);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: two instances (DEPTH 4 and DEPTH 2) share stimulus; each has its
// own in-order memory model and an abstract fetch model checked every cycle.
module tb_fetch_queue;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned MAX_OUT  = 2;
    localparam int unsigned DEPTH_A  = 4;
    localparam int unsigned DEPTH_B  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    typedef struct {
        int unsigned pc;
        int unsigned resp_pc;
        int unsigned count;
        int unsigned inflight;
        int unsigned drop;
        bit          known;
    } model_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mem_req_t;

    logic        clk;
    logic        rst;
    logic        gnt;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    int unsigned lat;
    logic        rv_a, rv_b;
    logic [31:0] rd_a, rd_b;

    int          n_checks;
    int          n_fail;
    int unsigned cyc;
    model_t      ma, mb;
    mem_req_t    mqa[$];
    mem_req_t    mqb[$];
    mem_req_t    ea, eb;

    fetch_queue_if #(.XLEN(XLEN)) bus_a ();
    fetch_queue_if #(.XLEN(XLEN)) bus_b ();

    assign bus_a.imem_gnt    = gnt;
    assign bus_a.imem_rvalid = rv_a;
    assign bus_a.imem_rdata  = rd_a;
    assign bus_a.redirect    = redirect;
    assign bus_a.redirect_pc = redirect_pc;
    assign bus_a.id_ready    = ready;
    assign bus_b.imem_gnt    = gnt;
    assign bus_b.imem_rvalid = rv_b;
    assign bus_b.imem_rdata  = rd_b;
    assign bus_b.redirect    = redirect;
    assign bus_b.redirect_pc = redirect_pc;
    assign bus_b.id_ready    = ready;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH_A), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .io_fq (bus_a)
    );

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH_B), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .io_fq (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is a fixed scramble of the address, so any word identifies its PC.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_req(input model_t m, input int unsigned depth, input bit r, input bit rd);
        return !r && !rd && (m.inflight < MAX_OUT) && ((m.count + m.inflight) < depth);
    endfunction

    // Abstract fetch model: the queue holds consecutive PCs ending just below resp_pc,
    // so the head PC is resp_pc - 4*count.
    function automatic model_t model_next(input model_t m, input int unsigned depth, input bit r,
                                          input bit rd, input logic [31:0] rdpc, input bit g,
                                          input bit rv, input bit rdy);
        model_t n;
        bit     grant;
        bit     pop;
        n = m;
        if (r) begin
            n.pc = RESET_PC; n.resp_pc = RESET_PC;
            n.count = 0; n.inflight = 0; n.drop = 0; n.known = 1'b1;
            return n;
        end
        if (!m.known) return n;
        if (rd) begin
            n.pc       = rdpc & 32'hFFFF_FFFC;
            n.resp_pc  = n.pc;
            n.count    = 0;
            n.inflight = m.inflight - (rv ? 1 : 0);
            n.drop     = n.inflight;
            return n;
        end
        grant = exp_req(m, depth, 1'b0, 1'b0) && g;
        pop   = (m.count != 0) && rdy;
        if (rv) begin
            if (m.drop > 0) n.drop--;
            else begin
                n.count++;
                n.resp_pc += 4;
            end
            n.inflight--;
        end
        if (grant) begin
            n.pc += 4;
            n.inflight++;
        end
        if (pop) n.count--;
        return n;
    endfunction

    task automatic check_dut(input string tag, input model_t m, input int unsigned depth,
                             input logic req, input logic [31:0] addr, input logic valid,
                             input logic [31:0] inst, input logic [31:0] pc4);
        logic [31:0] head;
        if (m.known || rst)
            check({tag, ".imem_req"}, 32'(req), 32'(exp_req(m, depth, rst, redirect)));
        if (!m.known) return;
        check({tag, ".imem_addr"}, addr, m.pc);
        check({tag, ".id_valid"}, 32'(valid), 32'(m.count != 0));
        if (m.count != 0) begin
            head = m.resp_pc - 4 * m.count;
            check({tag, ".id_inst"}, inst, mem_word(head));
            check({tag, ".id_pc_plus4"}, pc4, head + 32'd4);
        end
    endtask

    // Compare, then advance model and memory bookkeeping with this cycle's inputs.
    always @(negedge clk) begin
        check_dut("A", ma, DEPTH_A, bus_a.imem_req, bus_a.imem_addr, bus_a.id_valid,
                  bus_a.id_inst, bus_a.id_pc_plus4);
        check_dut("B", mb, DEPTH_B, bus_b.imem_req, bus_b.imem_addr, bus_b.id_valid,
                  bus_b.id_inst, bus_b.id_pc_plus4);
        ma = model_next(ma, DEPTH_A, rst, redirect, redirect_pc, gnt, rv_a, ready);
        mb = model_next(mb, DEPTH_B, rst, redirect, redirect_pc, gnt, rv_b, ready);
        if (rst) begin
            mqa.delete();
            mqb.delete();
        end else begin
            if (rv_a) void'(mqa.pop_front());
            if (rv_b) void'(mqb.pop_front());
            if (bus_a.imem_req && gnt) begin
                ea.addr = bus_a.imem_addr; ea.due = cyc + lat; mqa.push_back(ea);
            end
            if (bus_b.imem_req && gnt) begin
                eb.addr = bus_b.imem_addr; eb.due = cyc + lat; mqb.push_back(eb);
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        rv_a = (mqa.size() != 0) && (mqa[0].due <= cyc);
        rd_a = (mqa.size() != 0) ? mem_word(mqa[0].addr) : 32'h0;
        rv_b = (mqb.size() != 0) && (mqb[0].due <= cyc);
        rd_b = (mqb.size() != 0) ? mem_word(mqb[0].addr) : 32'h0;
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive_edge(); rst = 1'b1; redirect = 1'b0;
        drive_edge();
        drive_edge(); rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit found;
        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; gnt = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0; lat = 1;
        rv_a = 1'b0; rv_b = 1'b0; rd_a = '0; rd_b = '0;

        // Reset then streaming: grant c0, response c1, first head c2.
        do_reset();
        sample(); check("stream.c0.valid", 32'(bus_a.id_valid), 0);
        check("stream.c0.addr", bus_a.imem_addr, 32'h100);
        drive_edge(); sample(); check("stream.c1.valid", 32'(bus_a.id_valid), 0);
        drive_edge(); sample(); check("stream.c2.valid", 32'(bus_a.id_valid), 1);
        check("stream.c2.pc4", bus_a.id_pc_plus4, 32'h104);
        check("stream.c2.inst", bus_a.id_inst, mem_word(32'h100));
        for (int i = 1; i <= 2; i++) begin
            drive_edge(); sample();
            check("stream.next.pc4", bus_a.id_pc_plus4, 32'h104 + 32'(4 * i));
        end

        // Backpressure for 10 cycles: four entries 0x110..0x11C buffered, requests stop.
        drive_edge(); ready = 1'b0;
        sample(); check("bp.head0", bus_a.id_pc_plus4, 32'h110);
        repeat (9) begin drive_edge(); sample(); end
        check("bp.valid", 32'(bus_a.id_valid), 1);
        check("bp.head", bus_a.id_pc_plus4, 32'h110);
        check("bp.req", 32'(bus_a.imem_req), 0);
        check("bp.addr", bus_a.imem_addr, 32'h11C);
        drive_edge(); ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) drive_edge();
            sample();
            check("drain.pc4", bus_a.id_pc_plus4, 32'h110 + 32'(4 * i));
        end

        // Redirect with two requests in flight, latency 3: both stale words dropped.
        lat = 3;
        do_reset();
        sample();
        drive_edge(); sample();
        drive_edge(); redirect = 1'b1; redirect_pc = 32'h2003; sample();
        drive_edge(); redirect = 1'b0; sample();
        check("redir.addr", bus_a.imem_addr, 32'h2000);
        check("redir.valid", 32'(bus_a.id_valid), 0);
        check("redir.req_credit", 32'(bus_a.imem_req), 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            drive_edge(); sample();
            found = bus_a.id_valid;
        end
        check("redir.first_valid", 32'(found), 1);
        check("redir.first_pc4", bus_a.id_pc_plus4, 32'h2004);
        check("redir.first_inst", bus_a.id_inst, mem_word(32'h2000));

        // Redirect coinciding with a response and a pop.
        lat = 1;
        do_reset();
        sample();
        drive_edge(); sample();
        drive_edge(); sample();
        drive_edge(); redirect = 1'b1; redirect_pc = 32'h3000; sample();
        check("coinc.rvalid", 32'(rv_a), 1);
        drive_edge(); redirect = 1'b0; sample();
        check("coinc.valid", 32'(bus_a.id_valid), 0);
        check("coinc.req", 32'(bus_a.imem_req), 1);
        check("coinc.addr", bus_a.imem_addr, 32'h3000);
        drive_edge(); sample(); check("coinc.valid2", 32'(bus_a.id_valid), 0);
        drive_edge(); sample(); check("coinc.first_pc4", bus_a.id_pc_plus4, 32'h3004);
        check("coinc.first_inst", bus_a.id_inst, mem_word(32'h3000));

        // Address wrap-around.
        drive_edge(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; sample();
        drive_edge(); redirect = 1'b0; sample();
        drive_edge(); sample();
        drive_edge(); sample();
        check("wrap.valid", 32'(bus_a.id_valid), 1);
        check("wrap.pc4_0", bus_a.id_pc_plus4, 32'h0);
        check("wrap.inst_0", bus_a.id_inst, mem_word(32'hFFFF_FFFC));
        drive_edge(); sample();
        check("wrap.pc4_1", bus_a.id_pc_plus4, 32'h4);

        // Random ready/grant/latency/redirect patterns, checked by the model on both queues.
        for (int i = 0; i < 100; i++) begin
            drive_edge();
            gnt         = 1'($urandom_range(0, 1));
            ready       = 1'($urandom_range(0, 1));
            lat         = $urandom_range(1, 3);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
        end

        // Fill the queue, then reset mid-stream.
        drive_edge(); redirect = 1'b0; gnt = 1'b1; ready = 1'b0; lat = 1;
        repeat (9) drive_edge();
        sample();
        check("full.valid", 32'(bus_a.id_valid), 1);
        check("full.req", 32'(bus_a.imem_req), 0);
        drive_edge(); rst = 1'b1; sample();
        check("rst.req_during", 32'(bus_a.imem_req), 0);
        drive_edge(); rst = 1'b0; sample();
        check("rst.valid", 32'(bus_a.id_valid), 0);
        check("rst.addr", bus_a.imem_addr, RESET_PC);
        check("rst.req_after", 32'(bus_a.imem_req), 1);
        repeat (4) begin drive_edge(); sample(); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
